// File: rtl/div16x8_seq.sv
// Sequential restoring divider: DVD_W-bit dividend / DVS_W-bit divisor, one quotient
// bit per clock, start/done handshake and a 7-segment display of the FSM state.
module div16x8_seq #(
  parameter int               DVD_W = 16,
  parameter int               DVS_W = 8,
  parameter logic [DVD_W-1:0] ERR_Q = '1
) (
  input  logic             clk,
  input  logic             reset_a,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  input  logic             start,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             done_flag,
  output logic             div_by_zero,
  output logic             busy,
  output logic             seg_a,
  output logic             seg_b,
  output logic             seg_c,
  output logic             seg_d,
  output logic             seg_e,
  output logic             seg_f,
  output logic             seg_g,
  output logic [2:0]       state_dbg
);

  // Handshake: a request is accepted on any rising edge where start is high and the
  // FSM is in IDLE, DONE or ERR; done_flag then stays high until the next accept.

  localparam int CNT_W = (DVD_W > 1) ? $clog2(DVD_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DVD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CALC = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [DVD_W-1:0] dvd_r;
  logic [DVS_W-1:0] dvs_r;
  logic [DVD_W-1:0] wq;
  logic [DVS_W-1:0] pr;
  logic [CNT_W-1:0] cnt;

  logic [DVS_W:0]   pr_sh;
  logic             ge;
  logic [DVS_W-1:0] pr_nxt;
  logic [DVD_W-1:0] wq_nxt;
  logic [6:0]       seg;

  // The true difference is always < divisor, so the low DVS_W bits are exact.
  always_comb begin
    pr_sh  = {pr, wq[DVD_W-1]};
    ge     = (pr_sh >= {1'b0, dvs_r});
    pr_nxt = ge ? (pr_sh[DVS_W-1:0] - dvs_r) : pr_sh[DVS_W-1:0];
    wq_nxt = {wq[DVD_W-2:0], ge};
  end

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_LOAD;
      S_LOAD:                state_nxt = (dvs_r == '0) ? S_ERR : S_CALC;
      S_CALC:                if (cnt == LAST) state_nxt = S_DONE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      dvd_r       <= '0;
      dvs_r       <= '0;
      wq          <= '0;
      pr          <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      done_flag   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            dvd_r       <= dividend;
            dvs_r       <= divisor;
            done_flag   <= 1'b0;
            div_by_zero <= 1'b0;
          end
        end
        S_LOAD: begin
          if (dvs_r == '0) begin
            quotient    <= ERR_Q;
            remainder   <= dvd_r[DVS_W-1:0];
            div_by_zero <= 1'b1;
            done_flag   <= 1'b1;
          end else begin
            cnt <= '0;
            pr  <= '0;
            wq  <= dvd_r;
          end
        end
        S_CALC: begin
          pr  <= pr_nxt;
          wq  <= wq_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            quotient  <= wq_nxt;
            remainder <= pr_nxt;
            done_flag <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Segment order {a,b,c,d,e,f,g}, active high.
  always_comb begin
    seg = 7'b0000000;
    case (state)
      S_IDLE:  seg = 7'b1111110;
      S_LOAD:  seg = 7'b0110000;
      S_CALC:  seg = 7'b1101101;
      S_DONE:  seg = 7'b1111001;
      S_ERR:   seg = 7'b1001111;
      default: seg = 7'b0000000;
    endcase
  end

  assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = seg;
  assign busy      = (state == S_LOAD) || (state == S_CALC);
  assign state_dbg = state;

endmodule

// File: tb/tb_div16x8_seq.sv
// Bench for div16x8_seq: directed handshake/error/reset scenarios plus a random sweep
// checked against plain integer division and a cycle-count model of the display.
module tb_div16x8_seq;

  logic        clk = 1'b0;
  logic        reset_a = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        done_flag, div_by_zero, busy;
  logic        seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
  logic [2:0]  state_dbg;

  int          total = 0;
  int          bad = 0;
  logic [15:0] prev_q = '0;
  logic [7:0]  prev_r = '0;
  logic [15:0] ra;
  logic [7:0]  rb;

  localparam int ST_IDLE = 0, ST_LOAD = 1, ST_CALC = 2, ST_DONE = 3, ST_ERR = 4;

  div16x8_seq dut (
    .clk(clk), .reset_a(reset_a), .dividend(dividend), .divisor(divisor), .start(start),
    .quotient(quotient), .remainder(remainder), .done_flag(done_flag),
    .div_by_zero(div_by_zero), .busy(busy),
    .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c), .seg_d(seg_d),
    .seg_e(seg_e), .seg_f(seg_f), .seg_g(seg_g), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  wire [6:0] seg = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

  function automatic logic [6:0] seg_code(input int st);
    case (st)
      ST_IDLE: return 7'b1111110;
      ST_LOAD: return 7'b0110000;
      ST_CALC: return 7'b1101101;
      ST_DONE: return 7'b1111001;
      ST_ERR:  return 7'b1001111;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one request and follows it edge by edge. n counts edges after the
  // accepting edge: LOAD at n=0, CALC until the result lands at n=lat.
  task automatic do_div(input logic [15:0] a, input logic [7:0] b, input int pulse_at);
    int          lat, st;
    logic [15:0] eq;
    logic [7:0]  er;
    logic [31:0] recon;
    lat = (b == 0) ? 1 : 17;
    if (b == 0) begin
      eq = 16'hFFFF;
      er = a[7:0];
    end else begin
      eq = a / b;
      er = a % b;
    end
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n <= lat; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      st = (n == lat) ? ((b == 0) ? ST_ERR : ST_DONE) : ((n == 0) ? ST_LOAD : ST_CALC);
      check("seg", 32'(seg), 32'(seg_code(st)));
      check("busy", 32'(busy), 32'(n < lat));
      check("done_flag", 32'(done_flag), 32'(n == lat));
      check("div_by_zero", 32'(div_by_zero), 32'((n == lat) && (b == 0)));
      if (n < lat) begin
        check("q_hold", 32'(quotient), 32'(prev_q));
        check("r_hold", 32'(remainder), 32'(prev_r));
      end
      if (pulse_at != 0 && n == pulse_at) begin
        dividend = 16'd500;
        divisor  = 8'd9;
        start    = 1'b1;
      end else if (pulse_at != 0 && n == pulse_at + 1) begin
        start = 1'b0;
      end
    end
    check("quotient", 32'(quotient), 32'(eq));
    check("remainder", 32'(remainder), 32'(er));
    if (b != 0) begin
      recon = 32'(quotient) * 32'(b) + 32'(remainder);
      check("invariant", recon, 32'(a));
      check("rem_lt_dvs", 32'(remainder < b), 32'd1);
    end
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    // Reset values before any clock edge.
    #1;
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_done", 32'(done_flag), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_seg", 32'(seg), 32'(seg_code(ST_IDLE)));
    @(posedge clk); #1;
    reset_a = 1'b1;
    @(posedge clk); #1;
    check("idle_seg", 32'(seg), 32'(seg_code(ST_IDLE)));
    check("idle_busy", 32'(busy), 32'd0);

    // Multiplier round trip, then DONE holds with start low.
    do_div(16'd935, 8'd85, 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("hold_seg", 32'(seg), 32'(seg_code(ST_DONE)));
      check("hold_done", 32'(done_flag), 32'd1);
      check("hold_q", 32'(quotient), 32'd11);
    end

    // Back-to-back: each request issued on the DONE-state cycle.
    do_div(16'd1000, 8'd7, 0);
    do_div(16'd65535, 8'd1, 0);
    do_div(16'd5, 8'd200, 0);

    // Divide by zero, then recovery.
    do_div(16'd100, 8'd0, 0);
    check("err_r_val", 32'(remainder), 32'h64);
    do_div(16'd10, 8'd3, 0);

    // A start pulse during CALC is ignored and not queued.
    do_div(16'd1000, 8'd7, 5);
    @(posedge clk); #1;
    check("noqueue_seg", 32'(seg), 32'(seg_code(ST_DONE)));
    check("noqueue_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of CALC, between clock edges.
    dividend = 16'd1000;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    reset_a = 1'b0;
    #1;
    check("arst_q", 32'(quotient), 32'd0);
    check("arst_r", 32'(remainder), 32'd0);
    check("arst_done", 32'(done_flag), 32'd0);
    check("arst_dbz", 32'(div_by_zero), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_seg", 32'(seg), 32'(seg_code(ST_IDLE)));
    @(posedge clk); #1;
    reset_a = 1'b1;
    @(posedge clk); #1;
    check("post_rst_seg", 32'(seg), 32'(seg_code(ST_IDLE)));
    check("post_rst_busy", 32'(busy), 32'd0);
    prev_q = '0;
    prev_r = '0;
    do_div(16'd255, 8'd16, 0);

    // Random sweep with nonzero divisors.
    for (int i = 0; i < 2000; i++) begin
      ra = 16'($urandom_range(65535, 0));
      rb = 8'($urandom_range(255, 1));
      do_div(ra, rb, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
